// File: rtl/exec_unit.sv
`default_nettype none
// exec_unit: single-issue ALU with a multi-cycle shift-add multiplier feeding a register-file write port.
// Rev 1.0
module exec_unit #(
   parameter int unsigned ZERO_REG_WRITE = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  op,
   input  logic [31:0] read1,
   input  logic [31:0] read2,
   input  logic [4:0]  dest,
   output logic        write,
   output logic [4:0]  writereg,
   output logic [31:0] data,
   output logic        busy
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLT = 3'b101;
   localparam logic [2:0] OP_SLL = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] acc_q, acc_d;
   logic [31:0] mcand_q, mcand_d;
   logic [31:0] mplier_q, mplier_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [4:0]  mdest_q, mdest_d;
   logic        write_q, write_d;
   logic [4:0]  writereg_q, writereg_d;
   logic [31:0] data_q, data_d;
   logic [31:0] alu_res;
   logic [31:0] acc_sum;

   function automatic logic dest_ok(input logic [4:0] d);
      return (ZERO_REG_WRITE != 0) || (d != 5'd0);
   endfunction

   always_comb begin
      alu_res = '0;
      case (op)
         OP_ADD:  alu_res = read1 + read2;
         OP_SUB:  alu_res = read1 - read2;
         OP_AND:  alu_res = read1 & read2;
         OP_OR:   alu_res = read1 | read2;
         OP_XOR:  alu_res = read1 ^ read2;
         OP_SLT:  alu_res = {31'd0, $signed(read1) < $signed(read2)};
         OP_SLL:  alu_res = read1 << read2[4:0];
         default: alu_res = '0;
      endcase
   end

   // Partial product for the current multiplier bit; also the final product on the last iteration.
   assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : 32'd0);

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      cnt_d      = cnt_q;
      mdest_d    = mdest_q;
      write_d    = 1'b0;
      writereg_d = writereg_q;
      data_d     = data_q;
      if (state_q == ST_IDLE) begin
         if (in_valid) begin
            if (op == OP_MUL) begin
               state_d  = ST_MUL;
               acc_d    = '0;
               mcand_d  = read1;
               mplier_d = read2;
               cnt_d    = '0;
               mdest_d  = dest;
            end else if (dest_ok(dest)) begin
               write_d    = 1'b1;
               writereg_d = dest;
               data_d     = alu_res;
            end
         end
      end else begin
         acc_d    = acc_sum;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + 5'd1;
         if (cnt_q == 5'd31) begin
            state_d = ST_IDLE;
            if (dest_ok(mdest_q)) begin
               write_d    = 1'b1;
               writereg_d = mdest_q;
               data_d     = acc_sum;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         acc_q      <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         cnt_q      <= '0;
         mdest_q    <= '0;
         write_q    <= 1'b0;
         writereg_q <= '0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         cnt_q      <= cnt_d;
         mdest_q    <= mdest_d;
         write_q    <= write_d;
         writereg_q <= writereg_d;
         data_q     <= data_d;
      end
   end

   assign in_ready = (state_q == ST_IDLE);
   assign busy     = (state_q == ST_MUL);
   assign write    = write_q;
   assign writereg = writereg_q;
   assign data     = data_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_unit.sv
`default_nettype none
// tb_exec_unit: drives two exec_unit instances (ZERO_REG_WRITE=0 and 1) and checks them against a cycle-level reference model.
// Rev 1.0
module tb_exec_unit;

   localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                          XOR_ = 3'd4, SLT = 3'd5, SLL = 3'd6, MUL = 3'd7;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] read1 = '0, read2 = '0;
   logic [4:0]  dest = '0;

   logic        ready_s [2];
   logic        write_s [2];
   logic        busy_s  [2];
   logic [4:0]  wreg_s  [2];
   logic [31:0] data_s  [2];

   exec_unit #(.ZERO_REG_WRITE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready_s[0]),
      .op(op), .read1(read1), .read2(read2), .dest(dest),
      .write(write_s[0]), .writereg(wreg_s[0]), .data(data_s[0]), .busy(busy_s[0])
   );

   exec_unit #(.ZERO_REG_WRITE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready_s[1]),
      .op(op), .read1(read1), .read2(read2), .dest(dest),
      .write(write_s[1]), .writereg(wreg_s[1]), .data(data_s[1]), .busy(busy_s[1])
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   longint      edge_n   = 0;
   bit          m_busy;
   longint      m_done;
   logic [4:0]  m_pdest;
   logic [31:0] m_pval;
   bit          exp_wr   [2];
   logic [4:0]  exp_reg  [2];
   logic [31:0] exp_data [2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] prod;
      prod = 64'(a) * 64'(b);
      case (o)
         ADD:     return a + b;
         SUB:     return a - b;
         AND_:    return a & b;
         OR_:     return a | b;
         XOR_:    return a ^ b;
         SLT:     return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         SLL:     return a << (b % 32);
         default: return prod[31:0];
      endcase
   endfunction

   task automatic issue(input logic [4:0] d, input logic [31:0] v);
      for (int k = 0; k < 2; k++) begin
         if (d != 5'd0 || k == 1) begin
            exp_wr[k]   = 1'b1;
            exp_reg[k]  = d;
            exp_data[k] = v;
         end
      end
   endtask

   task automatic model_reset();
      m_busy = 1'b0;
      m_done = 0;
      for (int k = 0; k < 2; k++) begin
         exp_wr[k]   = 1'b0;
         exp_reg[k]  = '0;
         exp_data[k] = '0;
      end
   endtask

   task automatic compare_outputs();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("in_ready[%0d]", k), 32'(ready_s[k]), 32'(!m_busy));
         check($sformatf("busy[%0d]", k),     32'(busy_s[k]),  32'(m_busy));
         check($sformatf("write[%0d]", k),    32'(write_s[k]), 32'(exp_wr[k]));
         check($sformatf("writereg[%0d]", k), 32'(wreg_s[k]),  32'(exp_reg[k]));
         check($sformatf("data[%0d]", k),     data_s[k],       exp_data[k]);
      end
   endtask

   // One clock: present inputs, advance the model at the edge, compare on the falling edge.
   task automatic step(input logic v, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] d);
      in_valid = v;
      op       = o;
      read1    = a;
      read2    = b;
      dest     = d;
      @(posedge clk);
      edge_n++;
      exp_wr[0] = 1'b0;
      exp_wr[1] = 1'b0;
      if (m_busy) begin
         if (edge_n == m_done) begin
            m_busy = 1'b0;
            issue(m_pdest, m_pval);
         end
      end else if (v) begin
         if (o == MUL) begin
            m_busy  = 1'b1;
            m_done  = edge_n + 32;
            m_pdest = d;
            m_pval  = ref_result(o, a, b);
         end else begin
            issue(d, ref_result(o, a, b));
         end
      end
      @(negedge clk);
      compare_outputs();
   endtask

   task automatic pulse_reset();
      #2;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("rst_busy[%0d]", k),  32'(busy_s[k]),  32'd0);
         check($sformatf("rst_write[%0d]", k), 32'(write_s[k]), 32'd0);
         check($sformatf("rst_wreg[%0d]", k),  32'(wreg_s[k]),  32'd0);
         check($sformatf("rst_data[%0d]", k),  data_s[k],       32'd0);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      compare_outputs();
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 40));
         default: return $urandom();
      endcase
   endfunction

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      compare_outputs();
      rst_n = 1'b1;
      step(1'b0, ADD, 32'd0, 32'd0, 5'd0);

      // Wrapping add
      step(1'b1, ADD, 32'hFFFF_FFFF, 32'd1, 5'd5);
      check("add_wrap_write", 32'(write_s[0]), 32'd1);
      check("add_wrap_reg",   32'(wreg_s[0]),  32'd5);
      check("add_wrap_data",  data_s[0],       32'h0000_0000);

      // Signed compare then subtract, back to back
      step(1'b1, SLT, 32'h8000_0000, 32'd1, 5'd3);
      check("slt_data", data_s[0], 32'd1);
      check("slt_reg",  32'(wreg_s[0]), 32'd3);
      step(1'b1, SUB, 32'd3, 32'd5, 5'd4);
      check("sub_write", 32'(write_s[0]), 32'd1);
      check("sub_data",  data_s[0], 32'hFFFF_FFFE);
      check("sub_reg",   32'(wreg_s[0]), 32'd4);

      // Multiply with a competing op held valid throughout
      step(1'b1, MUL, 32'h0001_0001, 32'h0000_FFFF, 5'd7);
      for (int i = 0; i < 31; i++) begin
         step(1'b1, ADD, 32'd1, 32'd2, 5'd9);
         check("mul_write_low", 32'(write_s[0]), 32'd0);
      end
      step(1'b1, ADD, 32'd1, 32'd2, 5'd9);
      check("mul_write", 32'(write_s[0]), 32'd1);
      check("mul_reg",   32'(wreg_s[0]),  32'd7);
      check("mul_data",  data_s[0],       32'hFFFF_FFFF);
      check("mul_ready", 32'(ready_s[0]), 32'd1);
      step(1'b1, ADD, 32'd1, 32'd2, 5'd9);
      check("after_mul_data", data_s[0], 32'd3);
      check("after_mul_reg",  32'(wreg_s[0]), 32'd9);
      step(1'b0, ADD, 32'd0, 32'd0, 5'd0);

      // Reset in the middle of a multiply
      step(1'b1, MUL, 32'h1234_5678, 32'h9ABC_DEF0, 5'd6);
      repeat (9) step(1'b0, ADD, 32'd0, 32'd0, 5'd0);
      pulse_reset();
      step(1'b1, ADD, 32'd10, 32'd20, 5'd8);
      check("post_rst_add", data_s[0], 32'd30);
      repeat (40) step(1'b0, ADD, 32'd0, 32'd0, 5'd0);

      // Register 0 destination
      step(1'b1, OR_, 32'h0000_00F0, 32'h0000_000F, 5'd0);
      check("r0_write_zrw0", 32'(write_s[0]), 32'd0);
      check("r0_write_zrw1", 32'(write_s[1]), 32'd1);
      check("r0_reg_zrw1",   32'(wreg_s[1]),  32'd0);
      check("r0_data_zrw1",  data_s[1],       32'h0000_00FF);

      // Shift amount masking
      step(1'b1, SLL, 32'h0000_0003, 32'd32, 5'd2);
      check("sll_mask", data_s[0], 32'h0000_0003);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic [4:0] d;
         d = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         step(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(), d);
      end
      repeat (35) step(1'b0, ADD, 32'd0, 32'd0, 5'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
